// File: rtl/ex_stage_unit.sv
// Execute stage of the 5-stage ARM pipeline: Val2 generation, ALU, branch target,
// NZCV status register and the registered EX/MEM boundary.
module ex_stage_unit #(
    parameter int WORD_WIDTH            = 32,
    parameter int REG_FILE_DEPTH        = 4,
    parameter int SIGNED_IMM_WIDTH      = 24,
    parameter int SHIFTER_OPERAND_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             freeze,
    input  logic                             MEM_R_EN_in,
    input  logic                             MEM_W_EN_in,
    input  logic                             WB_EN_in,
    input  logic                             Imm_in,
    input  logic                             B_in,
    input  logic                             S_in,
    input  logic [3:0]                       EX_CMD_in,
    input  logic [REG_FILE_DEPTH-1:0]        Dest_in,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
    input  logic [WORD_WIDTH-1:0]            PC_in,
    input  logic [WORD_WIDTH-1:0]            Val_Rn_in,
    input  logic [WORD_WIDTH-1:0]            Val_Rm_in,
    output logic                             Br_taken,
    output logic [WORD_WIDTH-1:0]            Br_addr,
    output logic [3:0]                       status_reg,
    output logic [WORD_WIDTH-1:0]            ALU_Res_out,
    output logic [WORD_WIDTH-1:0]            Val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0]        Dest_out,
    output logic                             WB_EN_out,
    output logic                             MEM_R_EN_out,
    output logic                             MEM_W_EN_out
);

    localparam int MSB = WORD_WIDTH - 1;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    // ---------------- Val2 generation ----------------
    logic [4:0]              rot_amt;
    logic [4:0]              shift_imm;
    logic [1:0]              shift_type;
    logic [WORD_WIDTH-1:0]   imm_ext;
    logic [2*WORD_WIDTH-1:0] imm_dbl;
    logic [2*WORD_WIDTH-1:0] rm_dbl;
    logic [WORD_WIDTH-1:0]   imm_rot;
    logic [WORD_WIDTH-1:0]   rm_shift;
    logic [WORD_WIDTH-1:0]   val2;

    assign rot_amt    = {shifter_operand_in[11:8], 1'b0};
    assign shift_imm  = shifter_operand_in[11:7];
    assign shift_type = shifter_operand_in[6:5];
    assign imm_ext    = WORD_WIDTH'(shifter_operand_in[7:0]);

    // Rotates are taken from the low half of a doubled word shifted right.
    assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
    assign rm_dbl  = {Val_Rm_in, Val_Rm_in} >> shift_imm;
    assign imm_rot = imm_dbl[MSB:0];

    always_comb begin
        rm_shift = Val_Rm_in;
        case (shift_type)
            2'b00:   rm_shift = Val_Rm_in << shift_imm;
            2'b01:   rm_shift = Val_Rm_in >> shift_imm;
            2'b10:   rm_shift = WORD_WIDTH'($signed(Val_Rm_in) >>> shift_imm);
            default: rm_shift = rm_dbl[MSB:0];
        endcase
    end

    // Load/store offsets are a plain 12-bit immediate, even when Imm_in is set.
    always_comb begin
        if (MEM_R_EN_in || MEM_W_EN_in)
            val2 = WORD_WIDTH'(shifter_operand_in);
        else if (Imm_in)
            val2 = imm_rot;
        else
            val2 = rm_shift;
    end

    // ---------------- ALU ----------------
    logic                  c_in;
    logic [WORD_WIDTH:0]   sum;
    logic [WORD_WIDTH-1:0] alu_res;
    logic                  flag_c;
    logic                  flag_v;
    logic                  flags_upd;
    logic [3:0]            nzcv_next;

    assign c_in = status_reg[1];

    always_comb begin
        sum       = '0;
        alu_res   = '0;
        flag_c    = status_reg[1];
        flag_v    = status_reg[0];
        flags_upd = 1'b1;
        case (EX_CMD_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = Val_Rn_in & val2;
            CMD_ORR: alu_res = Val_Rn_in | val2;
            CMD_EOR: alu_res = Val_Rn_in ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, Val_Rn_in} + {1'b0, val2}
                    + (WORD_WIDTH+1)'(EX_CMD_in == CMD_ADC ? c_in : 1'b0);
                alu_res = sum[MSB:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (Val_Rn_in[MSB] == val2[MSB]) && (alu_res[MSB] != Val_Rn_in[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // Rn - Val2 - !C == Rn + ~Val2 + C, so the carry-out is the no-borrow flag.
                sum = {1'b0, Val_Rn_in} + {1'b0, ~val2}
                    + (WORD_WIDTH+1)'(EX_CMD_in == CMD_SBC ? c_in : 1'b1);
                alu_res = sum[MSB:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (Val_Rn_in[MSB] != val2[MSB]) && (alu_res[MSB] != Val_Rn_in[MSB]);
            end
            default: flags_upd = 1'b0;
        endcase
    end

    assign nzcv_next = flags_upd ? {alu_res[MSB], (alu_res == '0), flag_c, flag_v}
                                 : status_reg;

    // ---------------- Branch target ----------------
    logic [WORD_WIDTH-1:0] br_offset;

    assign br_offset = {{(WORD_WIDTH-SIGNED_IMM_WIDTH-2){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                        signed_immediate_in, 2'b00};
    assign Br_taken  = B_in;
    assign Br_addr   = PC_in + br_offset;

    // ---------------- Status and EX/MEM registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg   <= '0;
            ALU_Res_out  <= '0;
            Val_Rm_out   <= '0;
            Dest_out     <= '0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
        end else if (!freeze) begin
            if (S_in)
                status_reg <= nzcv_next;
            ALU_Res_out  <= alu_res;
            Val_Rm_out   <= Val_Rm_in;
            Dest_out     <= Dest_in;
            WB_EN_out    <= WB_EN_in;
            MEM_R_EN_out <= MEM_R_EN_in;
            MEM_W_EN_out <= MEM_W_EN_in;
        end
    end

endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the ID/EX register outputs.
- Generates Val2 from the shifter operand, runs the ALU and computes the branch target.
- Owns the NZCV status register and holds the registered EX/MEM boundary that feeds the memory stage.
- Branch-taken and branch-address are combinational so IF and ID can be flushed in the same cycle.

Parameters:
- WORD_WIDTH, 32, datapath width
- REG_FILE_DEPTH, 4, destination register index width
- SIGNED_IMM_WIDTH, 24, branch offset width
- SHIFTER_OPERAND_WIDTH, 12, shifter operand width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold EX/MEM register and status register (memory stall)
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Imm_in, B_in, S_in  in  1 each  ID/EX control
- EX_CMD_in  in  4  ALU command
- Dest_in  in  REG_FILE_DEPTH  destination register
- signed_immediate_in  in  SIGNED_IMM_WIDTH  branch offset, in words
- shifter_operand_in  in  SHIFTER_OPERAND_WIDTH  operand-2 encoding
- PC_in  in  WORD_WIDTH  PC+4 of the instruction
- Val_Rn_in, Val_Rm_in  in  WORD_WIDTH each  register operands
- Br_taken  out  1  combinational, equals B_in
- Br_addr  out  WORD_WIDTH  combinational branch target
- status_reg  out  4  registered {N,Z,C,V}, fed back to ID
- ALU_Res_out  out  WORD_WIDTH  registered ALU result
- Val_Rm_out  out  WORD_WIDTH  registered store data
- Dest_out  out  REG_FILE_DEPTH  registered destination
- WB_EN_out, MEM_R_EN_out, MEM_W_EN_out  out  1 each  registered control

Behaviour:
- Reset (rst=0, async): all registered outputs and status_reg are cleared to 0 immediately, independent of clk. The first capture occurs on the first rising edge after rst is released.
- Val2 (combinational):
  - If MEM_R_EN_in or MEM_W_EN_in is 1: zero-extended shifter_operand_in[11:0]. This takes priority over Imm_in.
  - Else if Imm_in is 1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else: Val_Rm_in shifted by so[11:7] (shift_imm), type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Val_Rm_in unchanged for all types.
- ALU, with C_in = status_reg[1]; all arithmetic is 33-bit, C is bit 32:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2 (also used for LDR/STR address)
  - 0011 ADC: Rn+Val2+C_in
  - 0100 SUB/CMP: Rn-Val2, C = no-borrow
  - 0101 SBC: Rn-Val2-!C_in
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other command: result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res == 0).
  - C and V are updated by arithmetic ops only; V is signed overflow.
  - Logical ops and MOV/MVN keep the previous C and V.
- Status register: captures new flags on a rising edge when S_in=1 and freeze=0; otherwise holds.
- Br_addr = PC_in + (sign_extend(signed_immediate_in) << 2), 32-bit with wrap-around.
- EX/MEM register: one cycle latency. On a rising edge with freeze=0 it captures ALU result, Val_Rm_in (unshifted), Dest_in, WB_EN_in, MEM_R_EN_in and MEM_W_EN_in. With freeze=1 all registers hold.
- Simultaneous freeze=1 and S_in=1: no flag update.
- Branch in EX: the bubble arrives from ID flush as all-zero controls, which produces a zero ALU result and no write-back.

Test Plan:
- Reset: drive rst=0 mid-run with outputs nonzero → all outputs 0 without a clock edge; first edge after release captures inputs.
- Immediate ADD with S: Rn=5, Imm=1, so=0x0FF (rot 0), cmd 0010, S=1 → ALU_Res_out=0x104 next cycle, status_reg=0000. Then so=0x1FF (rot 1, i.e. ror 2) → Val2=0xC000003F.
- Shifted SUB/CMP: Rn=3, Rm=0x10, so={5'd2,2'b01,…} (LSR 2, Val2=4), cmd 0100, S=1 → result 0xFFFFFFFF, NZCV=1000. Then Rn=Val2 case → Z=1, C=1.
- ADC carry chain and overflow: C=1, Rn=0x7FFFFFFF, Val2=0 → result 0x80000000, N=1, V=1. ASR 4 of 0x80000000 → Val2=0xF8000000.
- Memory address: MEM_R_EN=1, Imm=1, so=0x804, Rn=0x100 → ALU_Res_out=0x904, i.e. the rotate is ignored.
- Branch and freeze: PC_in=0x20, imm=0xFFFFFE, B=1 → Br_taken=1, Br_addr=0x18 same cycle. freeze=1 with S=1 → outputs and NZCV unchanged.
